// File: rtl/sobel_gradient.sv
// rtl/sobel_gradient.sv - 3-stage Sobel L1 gradient magnitude with threshold and per-frame edge count
module sobel_gradient #(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAG_SHIFT   = 0,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     window_valid,
    input  logic [9*PIXEL_WIDTH-1:0] window_in,
    input  logic                     thresh_en,
    input  logic [PIXEL_WIDTH-1:0]   threshold,
    input  logic                     frame_start,
    output logic                     edge_valid,
    output logic [PIXEL_WIDTH-1:0]   edge_out,
    output logic [COUNT_WIDTH-1:0]   edge_count,
    output logic                     count_valid
);

    localparam int SW = PIXEL_WIDTH + 2;
    localparam int GW = PIXEL_WIDTH + 3;
    localparam logic [GW-1:0] C_MAX = GW'((1 << PIXEL_WIDTH) - 1);

    logic [PIXEL_WIDTH-1:0] w_p [0:8];

    genvar k;
    generate
        for (k = 0; k < 9; k++) begin : g_unpack
            assign w_p[k] = window_in[k*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    endgenerate

    // Stage 1: positive/negative halves of each kernel, all unsigned
    logic [SW-1:0] w_xp, w_xn, w_yp, w_yn;
    logic [SW-1:0] r_xp, r_xn, r_yp, r_yn;
    logic          r_v1;

    assign w_xp = SW'(w_p[2]) + {1'b0, w_p[5], 1'b0} + SW'(w_p[8]);
    assign w_xn = SW'(w_p[0]) + {1'b0, w_p[3], 1'b0} + SW'(w_p[6]);
    assign w_yp = SW'(w_p[6]) + {1'b0, w_p[7], 1'b0} + SW'(w_p[8]);
    assign w_yn = SW'(w_p[0]) + {1'b0, w_p[1], 1'b0} + SW'(w_p[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_xp <= '0;
            r_xn <= '0;
            r_yp <= '0;
            r_yn <= '0;
        end else begin
            r_v1 <= window_valid;
            if (window_valid) begin
                r_xp <= w_xp;
                r_xn <= w_xn;
                r_yp <= w_yp;
                r_yn <= w_yn;
            end
        end
    end

    // Stage 2: signed differences folded to absolute values
    logic [GW-1:0] w_gx, w_gy, w_gx_neg, w_gy_neg;
    logic [SW-1:0] w_ax, w_ay;
    logic [SW-1:0] r_ax, r_ay;
    logic          r_v2;

    assign w_gx     = {1'b0, r_xp} - {1'b0, r_xn};
    assign w_gy     = {1'b0, r_yp} - {1'b0, r_yn};
    assign w_gx_neg = -w_gx;
    assign w_gy_neg = -w_gy;
    assign w_ax     = w_gx[GW-1] ? w_gx_neg[SW-1:0] : w_gx[SW-1:0];
    assign w_ay     = w_gy[GW-1] ? w_gy_neg[SW-1:0] : w_gy[SW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_ax <= '0;
            r_ay <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_ax <= w_ax;
                r_ay <= w_ay;
            end
        end
    end

    // Stage 3: scale, clamp, threshold; the hit flag travels with the pixel
    logic [GW-1:0]          w_mag, w_s;
    logic [PIXEL_WIDTH-1:0] w_c;
    logic                   w_ge;
    logic [PIXEL_WIDTH-1:0] r_out;
    logic                   r_v3, r_hit;

    assign w_mag = {1'b0, r_ax} + {1'b0, r_ay};
    assign w_s   = w_mag >> MAG_SHIFT;
    assign w_c   = (w_s > C_MAX) ? C_MAX[PIXEL_WIDTH-1:0] : w_s[PIXEL_WIDTH-1:0];
    assign w_ge  = (w_c >= threshold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3  <= 1'b0;
            r_out <= '0;
            r_hit <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_hit <= w_ge;
                if (thresh_en) begin
                    r_out <= w_ge ? {PIXEL_WIDTH{1'b1}} : '0;
                end else begin
                    r_out <= w_c;
                end
            end
        end
    end

    // Frame counter: a hit coincident with frame_start opens the new frame
    logic                   w_hit;
    logic [COUNT_WIDTH-1:0] r_acc, r_count;
    logic                   r_cv;

    assign w_hit = r_v3 & r_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_cv    <= 1'b0;
        end else if (frame_start) begin
            r_count <= r_acc;
            r_cv    <= 1'b1;
            r_acc   <= COUNT_WIDTH'(w_hit);
        end else begin
            r_cv <= 1'b0;
            if (w_hit && (r_acc != {COUNT_WIDTH{1'b1}})) begin
                r_acc <= r_acc + 1'b1;
            end
        end
    end

    assign edge_valid  = r_v3;
    assign edge_out    = r_out;
    assign edge_count  = r_count;
    assign count_valid = r_cv;

endmodule
